// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - FIFO read-mode constants and pointer wrap helper
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// rtl/param_sync_fifo_if.sv - write/read/status bundle between a FIFO and its user
interface param_sync_fifo_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  w_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  r_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output w_en, data_in, r_en, err_clr,
    input  data_out, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en, err_clr,
    output data_out, valid, full, empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - simple dual-port RAM, one write port, one registered read port
module fifo_ram #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read-before-write on a shared address; only the output register is reset.
  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - synchronous FIFO, any depth, standard or first-word-fall-through read
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = FIFO_STD,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input logic              clk,
  input logic              rst,
  param_sync_fifo_if.slave bus
);

  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);
  localparam bit IS_FWFT = (FWFT == FIFO_FWFT);

  logic [AW-1:0]         wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, ram_raddr;
  logic [CW-1:0]         count;
  logic                  w_acc, r_acc, ram_re;
  logic                  valid_q, byp_sel, ov_q, un_q;
  logic [DATA_WIDTH-1:0] byp_data, ram_q;
  int unsigned           count_i;

  // valid==(count!=0) in FWFT mode, so both modes accept a read on the same rule.
  assign r_acc      = bus.r_en && (count != '0);
  assign w_acc      = bus.w_en && ((count != CW'(DEPTH)) || r_acc);
  assign wr_ptr_nxt = AW'(ptr_inc(32'(wr_ptr), DEPTH));
  assign rd_ptr_nxt = AW'(ptr_inc(32'(rd_ptr), DEPTH));

  // FWFT keeps the RAM output tracking the head: it prefetches the successor on a read.
  assign ram_re    = IS_FWFT ? 1'b1 : r_acc;
  assign ram_raddr = (IS_FWFT && r_acc) ? rd_ptr_nxt : rd_ptr;

  fifo_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (w_acc && rst),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      byp_sel <= 1'b0;
      ov_q    <= 1'b0;
      un_q    <= 1'b0;
    end else begin
      if (w_acc) wr_ptr <= wr_ptr_nxt;
      if (r_acc) rd_ptr <= rd_ptr_nxt;
      count   <= count + CW'(w_acc) - CW'(r_acc);
      valid_q <= r_acc;
      // The written word becomes the head when nothing older survives this edge.
      byp_sel <= IS_FWFT && w_acc && (count == CW'(r_acc));
      if (w_acc) byp_data <= bus.data_in;
      ov_q    <= (ov_q && !bus.err_clr) || (bus.w_en && !w_acc);
      un_q    <= (un_q && !bus.err_clr) || (bus.r_en && !r_acc);
    end
  end

  assign count_i          = 32'(count);
  assign bus.data_out     = (IS_FWFT && byp_sel) ? byp_data : ram_q;
  assign bus.valid        = IS_FWFT ? (count != '0) : valid_q;
  assign bus.count        = count;
  assign bus.full         = (count == CW'(DEPTH));
  assign bus.empty        = (count == '0);
  assign bus.almost_full  = (count_i >= AF_LEVEL);
  assign bus.almost_empty = (count_i <= AE_LEVEL);
  assign bus.overflow     = ov_q;
  assign bus.underflow    = un_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// tb/tb_param_sync_fifo.sv - four FIFO variants driven in lockstep against queue models
module tb_param_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_en, r_en, err_clr;
  logic [7:0] data_in;

  logic [7:0] d_out [4];
  logic       vld   [4];
  logic [3:0] cnt   [4];
  logic [5:0] flg   [4];

  int         dep [4] = '{8, 8, 5, 5};
  bit         fw  [4] = '{0, 1, 0, 1};
  logic [7:0] mq  [4][$];
  logic [7:0] eq  [4][$];
  bit         m_ov [4];
  bit         m_un [4];
  logic [7:0] e_mon;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int DEP = (g < 2) ? 8 : 5;
    param_sync_fifo_if #(.DEPTH(DEP), .DATA_WIDTH(8)) bus ();
    assign bus.w_en    = w_en;
    assign bus.data_in = data_in;
    assign bus.r_en    = r_en;
    assign bus.err_clr = err_clr;
    param_sync_fifo #(
      .DEPTH      (DEP),
      .DATA_WIDTH (8),
      .FWFT       (g % 2),
      .AF_LEVEL   (DEP - 1),
      .AE_LEVEL   (1)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
    assign d_out[g] = bus.data_out;
    assign vld[g]   = bus.valid;
    assign cnt[g]   = 4'(bus.count);
    assign flg[g]   = {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
                       bus.overflow, bus.underflow};
  end

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", nm, i, act, exp);
    end
  endtask

  task automatic check_state();
    for (int i = 0; i < 4; i++) begin
      int sz;
      sz = mq[i].size();
      chk("count", i, int'(cnt[i]), sz);
      chk("flags", i, int'(flg[i]),
          int'({sz == dep[i], sz == 0, sz >= dep[i] - 1, sz <= 1, m_ov[i], m_un[i]}));
      if (fw[i]) begin
        chk("fwft_valid", i, int'(vld[i]), int'(sz != 0));
        if (sz != 0) chk("fwft_head", i, int'(d_out[i]), int'(mq[i][0]));
      end
    end
  endtask

  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit clr);
    bit ra [4];
    bit wa [4];
    logic [7:0] v;
    w_en = w; data_in = d; r_en = r; err_clr = clr;
    for (int i = 0; i < 4; i++) begin
      ra[i] = r && (mq[i].size() > 0);
      wa[i] = w && ((mq[i].size() < dep[i]) || ra[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (ra[i]) begin
        v = mq[i].pop_front();
        if (!fw[i]) eq[i].push_back(v);
      end
      if (wa[i]) mq[i].push_back(d);
      m_ov[i] = (m_ov[i] && !clr) || (w && !wa[i]);
      m_un[i] = (m_un[i] && !clr) || (r && !ra[i]);
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic do_reset(input bit w, input bit r, input bit clr);
    rst = 1'b0; w_en = w; r_en = r; err_clr = clr; data_in = 8'h5A;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      mq[i].delete();
      eq[i].delete();
      m_ov[i] = 1'b0;
      m_un[i] = 1'b0;
    end
    @(negedge clk);
    rst = 1'b1; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0;
    check_state();
    for (int i = 0; i < 4; i++) begin
      chk("rst_dout", i, int'(d_out[i]), 0);
      chk("rst_valid", i, int'(vld[i]), 0);
    end
  endtask

  // Standard-mode read data is matched against what the model popped one edge earlier.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!fw[i] && (vld[i] === 1'b1 || eq[i].size() > 0)) begin
        chk("std_valid", i, int'(vld[i]), int'(eq[i].size() > 0));
        if (eq[i].size() > 0) begin
          e_mon = eq[i].pop_front();
          chk("std_rdata", i, int'(d_out[i]), int'(e_mon));
        end
      end
    end
  end

  initial begin
    rst = 1'b0; w_en = 1'b0; r_en = 1'b0; err_clr = 1'b0; data_in = '0;
    do_reset(1'b1, 1'b1, 1'b1);

    for (int k = 0; k < 8; k++) cycle(1'b1, 8'h11 + 8'(k), 1'b0, 1'b0);
    chk("fill8_count", 0, int'(cnt[0]), 8);
    chk("fill8_full", 0, int'(flg[0][5]), 1);
    cycle(1'b1, 8'h99, 1'b0, 1'b0);
    chk("ninth_overflow", 0, int'(flg[0][1]), 1);
    for (int k = 0; k < 8; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained_empty", 0, int'(flg[0][4]), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("extra_underflow", 0, int'(flg[0][0]), 1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);

    do_reset(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("fwft_a5_data", 1, int'(d_out[1]), 8'hA5);
    chk("fwft_a5_valid", 1, int'(vld[1]), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("fwft_ack_valid", 1, int'(vld[1]), 0);
    chk("fwft_ack_empty", 1, int'(flg[1][4]), 1);

    for (int k = 0; k < 8; k++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (4) cycle(1'b1, 8'($urandom), 1'b1, 1'b0);
    chk("full_rw_count", 2, int'(cnt[2]), 5);
    chk("full_rw_ovf", 2, int'(flg[2][1]), 0);
    cycle(1'b1, 8'($urandom), 1'b0, 1'b1);
    chk("clr_vs_err", 2, int'(flg[2][1]), 1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("pre_rst_count", 2, int'(cnt[2]), 3);
    do_reset(1'b1, 1'b1, 1'b0);
    chk("post_rst_count", 2, int'(cnt[2]), 0);
    chk("post_rst_ovf", 2, int'(flg[2][1]), 0);

    repeat (300) cycle($urandom_range(9) < 6, 8'($urandom), $urandom_range(1) == 1,
                       $urandom_range(15) == 0);
    repeat (10) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("pending_reads", i, eq[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, giving the number of storage words; any integer 2..4096 is legal, and a power of two is not required.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, giving the word width in bits.
REQ-003 The module SHALL have parameter FWFT, default 0, selecting the read mode: 0 = standard registered read, 1 = first-word-fall-through.
REQ-004 The module SHALL have parameter AF_LEVEL, default DEPTH-1, the count at or above which almost_full asserts.
REQ-005 The module SHALL have parameter AE_LEVEL, default 1, the count at or below which almost_empty asserts.
REQ-006 clk  in  1  sole clock; all logic is on the rising edge.
REQ-007 rst  in  1  reset; synchronous, active-low.
REQ-008 w_en  in  1  write request.
REQ-009 data_in  in  DATA_WIDTH  write data.
REQ-010 r_en  in  1  read request (standard mode) or read acknowledge (FWFT mode).
REQ-011 data_out  out  DATA_WIDTH  read data.
REQ-012 valid  out  1  data_out holds a valid word.
REQ-013 full, empty, almost_full, almost_empty  out  1 each  status flags.
REQ-014 count  out  $clog2(DEPTH+1)  number of words held.
REQ-015 overflow, underflow  out  1 each  sticky error flags.
REQ-016 err_clr  in  1  clears both sticky error flags.

Function
REQ-017 A write SHALL be accepted when w_en=1 and either full=0, or full=1 with a read accepted in the same cycle.
REQ-018 A read SHALL be accepted when r_en=1 and empty=0 in standard mode, or when r_en=1 and valid=1 in FWFT mode.
REQ-019 Pointers SHALL wrap from DEPTH-1 to 0; count SHALL be used for full/empty (full = count==DEPTH, empty = count==0).
REQ-020 On an accepted write or read, count SHALL change by +1 or -1 on the next edge; simultaneous accepted write and read SHALL leave count unchanged.
REQ-021 In standard mode, an accepted read at edge N SHALL drive data_out at N+1 with valid=1 for exactly one cycle; data_out SHALL hold its value otherwise.
REQ-022 In FWFT mode, valid SHALL equal (count!=0) and data_out SHALL present the oldest word while valid=1.
REQ-023 In FWFT mode, a write into an empty FIFO at edge N SHALL appear on data_out with valid=1 from N+1, via a bypass path.
REQ-024 Simultaneous write and read on an empty FIFO SHALL accept only the write in standard mode; in FWFT mode the read is not accepted because valid=0.
REQ-025 The flags SHALL be combinational functions of count: almost_full = count>=AF_LEVEL, almost_empty = count<=AE_LEVEL.
REQ-026 w_en=1 while a write is not accepted SHALL set overflow; r_en=1 while a read is not accepted SHALL set underflow; data and pointers SHALL be unchanged.
REQ-027 err_clr=1 SHALL clear both sticky flags at the next edge; a same-cycle error event SHALL take priority and set its flag.
REQ-028 Storage SHALL be a simple dual-port RAM with a registered read, suitable for block RAM inference.

Reset
REQ-029 While rst=0 at an edge, the pointers and count SHALL go to 0, and data_out, valid, overflow and underflow SHALL go to 0.
REQ-030 After that edge, full=0, empty=1, almost_empty=1, and almost_full=(AF_LEVEL==0).
REQ-031 Reset SHALL override concurrent w_en, r_en and err_clr; RAM contents are not cleared.
REQ-032 A write or read in flight when reset arrives SHALL be discarded, and no flag SHALL pulse after reset.

Structure
REQ-033 Package fifo_pkg SHALL hold the FWFT mode constants (FIFO_STD=0, FIFO_FWFT=1) and a pointer-increment-with-wrap function.
REQ-034 One sub-module, fifo_ram (simple dual-port, registered read, DEPTH x DATA_WIDTH), SHALL hold the storage.

Verification
REQ-035 DEPTH=8, standard mode: write 0x11..0x18 -> full=1, count=8; a 9th write sets overflow=1 and the contents are unchanged.
REQ-036 Standard mode: read 8 times -> data_out 0x11..0x18, each with one valid pulse one cycle after r_en; then empty=1; a further r_en sets underflow=1.
REQ-037 FWFT mode: a single write of 0xA5 at edge N -> data_out=0xA5 and valid=1 at N+1; r_en at N+1 -> valid=0 and empty=1 at N+2.
REQ-038 DEPTH=5 (not a power of two): 20 random interleaved operations match a reference model, with pointer wrap exercised and count never exceeding 5.
REQ-039 Full FIFO plus simultaneous w_en/r_en -> both accepted, count stays 5, overflow stays 0; AF_LEVEL=4 -> almost_full toggles exactly at the 3->4 and 4->3 count transitions.
REQ-040 Apply rst=0 mid-burst with count=3 and overflow=1 -> next cycle count=0, empty=1, valid=0, overflow=0; err_clr and an error in the same cycle -> flag stays 1.
